// File: rtl/inst_fetch_stage.sv
// Instruction fetch front-end: PC register driving a combinational-read SRAM,
// with a show-ahead prefetch FIFO to decode that is flushed by execute redirects.
module inst_fetch_stage #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_WIDTH-1:0]        addr_0,
  input  logic [DATA_WIDTH-1:0]        inst_in,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_inst,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] memPc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] memInst_q [DEPTH];

  logic pop;
  logic push;

  assign pop  = (count_q != '0) && out_ready;
  // A full FIFO can still accept a fetch when the head leaves in the same cycle.
  assign push = !redirect_valid && ((count_q < CNT_W'(DEPTH)) || pop);

  always_comb begin
    fetchPc_d = fetchPc_q;
    count_d   = count_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    if (redirect_valid) begin
      fetchPc_d = redirect_pc;
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end else begin
      if (push) begin
        wrPtr_d   = wrPtr_q + PTR_W'(1);
        fetchPc_d = fetchPc_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q <= RESET_PC;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      memPc_q[wrPtr_q]   <= fetchPc_q;
      memInst_q[wrPtr_q] <= inst_in;
    end
  end

  assign addr_0     = fetchPc_q;
  assign out_valid  = (count_q != '0);
  assign out_inst   = memInst_q[rdPtr_q];
  assign out_pc     = memPc_q[rdPtr_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed self-checking bench for inst_fetch_stage: a vector table for streaming,
// stall, full-FIFO and redirect behaviour, plus hand-written wrap and reset sequences.
module tb_inst_fetch_stage;

  logic        clk;
  logic        reset;
  logic [15:0] addr_0;
  logic [15:0] inst_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic        out_ready;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        ev;
    logic [2:0]  ec;
    logic [15:0] ea;
    logic [15:0] epc;
    logic [15:0] ei;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_stage #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DEPTH(4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr_0(addr_0),
    .inst_in(inst_in),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction SRAM model: mem[i] = 16'h1000 + i, combinational read.
  assign inst_in = 16'h1000 + addr_0;

  task automatic addVec(input logic rst, input logic rv, input logic [15:0] rpc,
                        input logic rdy, input logic ev, input logic [2:0] ec,
                        input logic [15:0] ea, input logic [15:0] epc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.ea = ea; v.epc = epc;
    v.ei = 16'h1000 + epc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [15:0] rpc,
                               input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [2:0] ec,
                             input logic [15:0] ea, input logic [15:0] epc,
                             input logic [15:0] ei);
    checkOne({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ev});
    checkOne({tag, ".fifo_count"}, {13'd0, fifo_count}, {13'd0, ec});
    checkOne({tag, ".addr_0"}, addr_0, ea);
    if (ev) begin
      checkOne({tag, ".out_pc"}, out_pc, epc);
      checkOne({tag, ".out_inst"}, out_inst, ei);
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b1;

    // Streaming from reset with out_ready=1
    addVec(1, 0, 16'h0, 1, 0, 3'd0, 16'h0000, 16'h0000);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0001, 16'h0000);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0002, 16'h0001);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0003, 16'h0002);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0004, 16'h0003);
    // Reset, then stall 10 cycles: fills to 4 and holds pc 0 at head
    addVec(1, 0, 16'h0, 0, 0, 3'd0, 16'h0000, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd1, 16'h0001, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd2, 16'h0002, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd3, 16'h0003, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd4, 16'h0004, 16'h0000);
    for (int i = 0; i < 6; i++)
      addVec(0, 0, 16'h0, 0, 1, 3'd4, 16'h0004, 16'h0000);
    // Release while full: push+pop together, count stays 4, stream continuous
    addVec(0, 0, 16'h0, 1, 1, 3'd4, 16'h0005, 16'h0001);
    addVec(0, 0, 16'h0, 1, 1, 3'd4, 16'h0006, 16'h0002);
    addVec(0, 0, 16'h0, 1, 1, 3'd4, 16'h0007, 16'h0003);
    addVec(0, 0, 16'h0, 1, 1, 3'd4, 16'h0008, 16'h0004);
    // Build 3 entries, then redirect to 0x0040 (same-cycle pop still allowed)
    addVec(1, 0, 16'h0, 0, 0, 3'd0, 16'h0000, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd1, 16'h0001, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd2, 16'h0002, 16'h0000);
    addVec(0, 0, 16'h0, 0, 1, 3'd3, 16'h0003, 16'h0000);
    addVec(0, 1, 16'h0040, 1, 0, 3'd0, 16'h0040, 16'h0000);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0041, 16'h0040);
    addVec(0, 0, 16'h0, 1, 1, 3'd1, 16'h0042, 16'h0041);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ea,
                  vecs[i].epc, vecs[i].ei);
    end

    // PC wrap: redirect to 0xFFFE with decode always ready
    applyStimulus(0, 1, 16'hFFFE, 1);
    checkOutput("wrap0", 0, 3'd0, 16'hFFFE, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("wrap1", 1, 3'd1, 16'hFFFF, 16'hFFFE, 16'h0FFE);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("wrap2", 1, 3'd1, 16'h0000, 16'hFFFF, 16'h0FFF);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("wrap3", 1, 3'd1, 16'h0001, 16'h0000, 16'h1000);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("wrap4", 1, 3'd1, 16'h0002, 16'h0001, 16'h1001);

    // Reset mid-operation with partial FIFO and a redirect on the same edge
    applyStimulus(0, 0, 16'h0000, 0);
    checkOutput("mid0", 1, 3'd2, 16'h0003, 16'h0001, 16'h1001);
    applyStimulus(1, 1, 16'h1234, 0);
    checkOutput("mid1", 0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("mid2", 1, 3'd1, 16'h0001, 16'h0000, 16'h1000);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("mid3", 1, 3'd1, 16'h0002, 16'h0001, 16'h1001);
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("mid4", 1, 3'd1, 16'h0003, 16'h0002, 16'h1002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
Instruction fetch front-end that sits between the instruction SRAM and the decode stage of pipelined_cpu. It holds the program counter, drives the asynchronous instruction SRAM address, and captures the returned word in the same cycle. Fetched {pc, instruction} pairs are buffered in a small FIFO and delivered to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, PC / SRAM address width (word addressed)
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
addr_0  output  ADDR_WIDTH  instruction SRAM address (combinational read)
inst_in  input  DATA_WIDTH  instruction SRAM read data, valid same cycle as addr_0
redirect_valid  input  1  execute stage requests PC change this cycle
redirect_pc  input  ADDR_WIDTH  new PC for the redirect
out_valid  output  1  FIFO head holds a valid instruction
out_inst  output  DATA_WIDTH  instruction at FIFO head
out_pc  output  ADDR_WIDTH  PC of out_inst
out_ready  input  1  decode accepts head this cycle
fifo_count  output  log2(DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- Reset (clk edge with reset=1): fetch_pc<=RESET_PC, count<=0, rd/wr pointers<=0. Outputs after reset: out_valid=0, fifo_count=0, addr_0=RESET_PC; out_inst/out_pc are don't-care while out_valid=0.
- addr_0 = fetch_pc, purely from the register (no combinational path from redirect inputs).
- pop = out_valid & out_ready. push = !redirect_valid & (count<DEPTH | pop).
- On push: FIFO[wr] <= {fetch_pc, inst_in}; wr++; fetch_pc <= fetch_pc+1 (mod 2^ADDR_WIDTH; 0xFFFF wraps to 0x0000).
- On pop: rd++. count updates by push-pop; push and pop in the same cycle leaves count unchanged, including when full.
- Full with no pop: no push, fetch_pc holds, addr_0 stable.
- Redirect (priority over everything else, except reset): count<=0, pointers<=0, fetch_pc<=redirect_pc, no push. A pop in the same cycle is still honoured by decode (the handshake completes), but the FIFO is emptied regardless.
- Head outputs are show-ahead: out_valid=(count!=0); out_inst/out_pc = FIFO[rd], and these are stable while out_valid=1 & out_ready=0.
- Latency:
  - A push at cycle N makes the entry visible at cycle N+1 if the FIFO was empty.
  - After a redirect at cycle N, the redirect_pc instruction is fetched at N+1 and appears on out at N+2.
  - After reset deassertion, the first fetch occurs on the first edge with reset=0, and out_valid=1 on the next cycle.
- Steady state with out_ready held at 1: one instruction per cycle, with consecutive PCs.
- Reset asserted mid-operation discards all FIFO contents and any pending redirect.

Test Plan:
- Reset, SRAM mem[i]=16'h1000+i, out_ready=1 -> out_valid rises 1 cycle after release; out_pc=0,1,2,3... every cycle, out_inst=16'h1000,16'h1001,...
- out_ready=0 for 10 cycles -> fifo_count saturates at 4, addr_0 holds at 4, head stays pc=0. Then release -> pcs 0..3 are drained in order, with no gaps or duplicates.
- While FIFO is full, assert out_ready=1 -> push and pop occur in the same cycle, fifo_count stays 4, and the stream stays continuous.
- redirect_valid=1, redirect_pc=16'h0040, FIFO holding 3 entries -> fifo_count=0 next cycle; two cycles later out_pc=16'h0040, out_inst=mem[0x40]; stale pcs never appear.
- redirect_pc=16'hFFFE, out_ready=1 -> out_pc sequence FFFE, FFFF, 0000, 0001.
- Assert reset while the FIFO is partially full and a redirect is pending -> out_valid=0, fifo_count=0, addr_0=RESET_PC after the edge; the restart matches the first scenario.
